// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO controller: I/O register offsets relative
// to the region base, and the TX handoff state encoding.
package mmio_pkg;

  localparam logic [31:0] UART_CTRL = 32'h0000_0000;
  localparam logic [31:0] UART_RX   = 32'h0000_0004;
  localparam logic [31:0] UART_TX   = 32'h0000_0008;
  localparam logic [31:0] CYCLE     = 32'h0000_0010;
  localparam logic [31:0] INST      = 32'h0000_0014;
  localparam logic [31:0] CNT_CLR   = 32'h0000_0018;
  localparam logic [31:0] TOTAL_B   = 32'h0000_001C;
  localparam logic [31:0] CORR_B    = 32'h0000_0020;
  localparam logic [31:0] CNT_HALT  = 32'h0000_0024;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/mmio_ctrl_if.sv
// Bus bundle between the CPU pipeline / peripherals and mmio_ctrl.
// master: the pipeline/peripheral side; slave: the controller itself.
interface mmio_ctrl_if #(parameter int CNT_W = 32);
  logic             io_stall;
  logic [31:0]      io_addr;
  logic [31:0]      io_wdata;
  logic             io_we;
  logic             io_re;
  logic             io_inst_valid;
  logic             io_br_valid;
  logic             io_br_correct;
  logic             io_rx_fifo_empty;
  logic             io_rx_fifo_rd_en;
  logic             io_uart_tx_data_in_ready;
  logic             io_uart_tx_data_in_valid;
  logic [7:0]       io_uart_tx_data_in;
  logic             io_tx_idle;
  logic [31:0]      io_prev_data_addr;
  logic [CNT_W-1:0] io_cycle_p;
  logic [CNT_W-1:0] io_inst_p;
  logic [CNT_W-1:0] io_total_B_p;
  logic [CNT_W-1:0] io_corr_B_p;

  modport master (
    output io_stall, io_addr, io_wdata, io_we, io_re,
           io_inst_valid, io_br_valid, io_br_correct,
           io_rx_fifo_empty, io_uart_tx_data_in_ready,
    input  io_rx_fifo_rd_en, io_uart_tx_data_in_valid, io_uart_tx_data_in,
           io_tx_idle, io_prev_data_addr,
           io_cycle_p, io_inst_p, io_total_B_p, io_corr_B_p
  );

  modport slave (
    input  io_stall, io_addr, io_wdata, io_we, io_re,
           io_inst_valid, io_br_valid, io_br_correct,
           io_rx_fifo_empty, io_uart_tx_data_in_ready,
    output io_rx_fifo_rd_en, io_uart_tx_data_in_valid, io_uart_tx_data_in,
           io_tx_idle, io_prev_data_addr,
           io_cycle_p, io_inst_p, io_total_B_p, io_corr_B_p
  );
endinterface

// File: rtl/perf_counter.sv
// Wrapping performance counter. Clear beats increment; hold freezes counting
// but never blocks a clear.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic         hold,
  output logic [W-1:0] count
);

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset)              count <= '0;
    else if (clr)            count <= '0;
    else if (inc && !hold)   count <= count + W'(1);
  end

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO sequencing controller: address decode, UART TX byte handoff, RX FIFO
// pop, previous-address register and four performance counters.
// Optional macro MMIO_CNT_HALT_EN adds a counter halt bit at offset 0x24.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int          CNT_W   = 32,
  parameter logic [31:0] IO_BASE = 32'h8000_0000
) (
  input logic        clock,
  input logic        reset,
  mmio_ctrl_if.slave bus
);

  logic      active;
  logic      hit_rx, hit_tx, hit_clr;
  logic      st_tx, cnt_clr, halt;
  logic      tx_load;
  tx_state_e state, state_nxt;
  logic [7:0] tx_byte;
  logic [31:0] prev_addr;

  assign active  = !bus.io_stall;
  assign hit_rx  = (bus.io_addr == (IO_BASE + UART_RX));
  assign hit_tx  = (bus.io_addr == (IO_BASE + UART_TX));
  assign hit_clr = (bus.io_addr == (IO_BASE + CNT_CLR));

  assign st_tx   = active && bus.io_we && hit_tx;
  assign cnt_clr = active && bus.io_we && hit_clr;

  // A store in the same cycle as a load owns the access, so no pop then.
  assign bus.io_rx_fifo_rd_en = active && bus.io_re && !bus.io_we && hit_rx
                                && !bus.io_rx_fifo_empty;

`ifdef MMIO_CNT_HALT_EN
  logic hit_halt;
  logic halt_q;
  assign hit_halt = (bus.io_addr == (IO_BASE + CNT_HALT));

  // Halt bit written by a store to the halt offset.
  always_ff @(posedge clock) begin
    if (!reset)                                halt_q <= 1'b0;
    else if (active && bus.io_we && hit_halt)  halt_q <= bus.io_wdata[0];
  end
  assign halt = halt_q;
`else
  assign halt = 1'b0;
`endif

  // Previous data address tracks the pipeline, frozen while stalled.
  always_ff @(posedge clock) begin
    if (!reset)       prev_addr <= '0;
    else if (active)  prev_addr <= bus.io_addr;
  end
  assign bus.io_prev_data_addr = prev_addr;

  // TX FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // TX FSM next state; stores arriving outside IDLE are dropped.
  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    case (state)
      IDLE: if (st_tx) begin
        state_nxt = SEND;
        tx_load   = 1'b1;
      end
      SEND: if (bus.io_uart_tx_data_in_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // TX byte holding register, only loaded on entry to SEND so it stays stable.
  always_ff @(posedge clock) begin
    if (!reset)       tx_byte <= 8'h00;
    else if (tx_load) tx_byte <= bus.io_wdata[7:0];
  end

  assign bus.io_uart_tx_data_in       = tx_byte;
  assign bus.io_uart_tx_data_in_valid = (state == SEND);
  assign bus.io_tx_idle               = (state == IDLE);

  perf_counter #(.W(CNT_W)) u_cycle (
    .clock(clock), .reset(reset), .inc(1'b1), .clr(cnt_clr), .hold(halt),
    .count(bus.io_cycle_p)
  );

  perf_counter #(.W(CNT_W)) u_inst (
    .clock(clock), .reset(reset), .inc(bus.io_inst_valid), .clr(cnt_clr),
    .hold(halt), .count(bus.io_inst_p)
  );

  perf_counter #(.W(CNT_W)) u_total_b (
    .clock(clock), .reset(reset), .inc(bus.io_br_valid), .clr(cnt_clr),
    .hold(halt), .count(bus.io_total_B_p)
  );

  perf_counter #(.W(CNT_W)) u_corr_b (
    .clock(clock), .reset(reset),
    .inc(bus.io_br_valid && bus.io_br_correct), .clr(cnt_clr),
    .hold(halt), .count(bus.io_corr_B_p)
  );

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed self-checking bench for mmio_ctrl. Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns after that.
module tb_mmio_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mmio_ctrl_if #(.CNT_W(32)) bus ();

  mmio_ctrl u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_bus();
    bus.io_we  = 1'b0;
    bus.io_re  = 1'b0;
    bus.io_inst_valid = 1'b0;
    bus.io_br_valid   = 1'b0;
    bus.io_br_correct = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.io_addr  = a;
    bus.io_wdata = d;
    bus.io_we    = 1'b1;
    bus.io_re    = 1'b0;
  endtask

  initial begin
    bus.io_stall = 1'b0;
    bus.io_addr  = 32'h0;
    bus.io_wdata = 32'h0;
    bus.io_rx_fifo_empty = 1'b1;
    bus.io_uart_tx_data_in_ready = 1'b0;
    idle_bus();

    // Reset held for two edges.
    tick();
    tick();
    reset = 1'b1;
    settle();
    chk("rst_tx_idle", 64'(bus.io_tx_idle), 64'd1);
    chk("rst_tx_valid", 64'(bus.io_uart_tx_data_in_valid), 64'd0);
    chk("rst_tx_byte", 64'(bus.io_uart_tx_data_in), 64'h0);
    chk("rst_prev_addr", 64'(bus.io_prev_data_addr), 64'h0);
    chk("rst_cycle", 64'(bus.io_cycle_p), 64'd0);
    chk("rst_inst", 64'(bus.io_inst_p), 64'd0);
    chk("rst_total_b", 64'(bus.io_total_B_p), 64'd0);
    chk("rst_corr_b", 64'(bus.io_corr_B_p), 64'd0);

    for (int i = 0; i < 10; i++) tick();
    chk("free_cycle10", 64'(bus.io_cycle_p), 64'd10);
    chk("free_inst0", 64'(bus.io_inst_p), 64'd0);
    chk("free_total0", 64'(bus.io_total_B_p), 64'd0);
    chk("free_corr0", 64'(bus.io_corr_B_p), 64'd0);

    // TX: store 0x41, ready low for 3 SEND cycles then high on the 4th.
    store(32'h8000_0008, 32'h0000_0141);
    tick();
    idle_bus();
    settle();
    chk("tx_s1_valid", 64'(bus.io_uart_tx_data_in_valid), 64'd1);
    chk("tx_s1_byte", 64'(bus.io_uart_tx_data_in), 64'h41);
    chk("tx_s1_idle", 64'(bus.io_tx_idle), 64'd0);
    store(32'h8000_0008, 32'h0000_0042);
    tick();
    idle_bus();
    settle();
    chk("tx_s2_valid", 64'(bus.io_uart_tx_data_in_valid), 64'd1);
    chk("tx_drop_byte", 64'(bus.io_uart_tx_data_in), 64'h41);
    tick();
    chk("tx_s3_valid", 64'(bus.io_uart_tx_data_in_valid), 64'd1);
    tick();
    bus.io_uart_tx_data_in_ready = 1'b1;
    // Store landing on the handshake cycle must also be dropped.
    store(32'h8000_0008, 32'h0000_0077);
    settle();
    chk("tx_s4_valid", 64'(bus.io_uart_tx_data_in_valid), 64'd1);
    chk("tx_s4_byte", 64'(bus.io_uart_tx_data_in), 64'h41);
    tick();
    idle_bus();
    bus.io_uart_tx_data_in_ready = 1'b0;
    settle();
    chk("tx_done_valid", 64'(bus.io_uart_tx_data_in_valid), 64'd0);
    chk("tx_done_idle", 64'(bus.io_tx_idle), 64'd1);
    tick();
    chk("tx_hs_store_dropped", 64'(bus.io_tx_idle), 64'd1);

    // RX pop with FIFO non-empty.
    bus.io_addr = 32'h8000_0004;
    bus.io_re   = 1'b1;
    bus.io_rx_fifo_empty = 1'b0;
    settle();
    chk("rx_pop", 64'(bus.io_rx_fifo_rd_en), 64'd1);
    tick();
    bus.io_re   = 1'b0;
    bus.io_addr = 32'h0000_0000;
    settle();
    chk("rx_pop_one_cycle", 64'(bus.io_rx_fifo_rd_en), 64'd0);
    chk("rx_prev_addr", 64'(bus.io_prev_data_addr), 64'h8000_0004);
    // Empty FIFO: no pop.
    bus.io_addr = 32'h8000_0004;
    bus.io_re   = 1'b1;
    bus.io_rx_fifo_empty = 1'b1;
    settle();
    chk("rx_empty_nopop", 64'(bus.io_rx_fifo_rd_en), 64'd0);
    // Store and load together: store wins, no pop.
    bus.io_rx_fifo_empty = 1'b0;
    bus.io_we = 1'b1;
    settle();
    chk("rx_we_re_nopop", 64'(bus.io_rx_fifo_rd_en), 64'd0);
    // Near-miss address must not decode.
    bus.io_we   = 1'b0;
    bus.io_addr = 32'h0000_0004;
    settle();
    chk("rx_addr_miss", 64'(bus.io_rx_fifo_rd_en), 64'd0);
    tick();
    idle_bus();
    bus.io_rx_fifo_empty = 1'b1;

    // Counters: 5 instructions, 3 branches, 2 predicted correctly.
    for (int i = 0; i < 5; i++) begin
      bus.io_inst_valid = 1'b1;
      bus.io_br_valid   = (i < 3);
      bus.io_br_correct = (i < 2);
      tick();
    end
    idle_bus();
    chk("cnt_inst5", 64'(bus.io_inst_p), 64'd5);
    chk("cnt_total3", 64'(bus.io_total_B_p), 64'd3);
    chk("cnt_corr2", 64'(bus.io_corr_B_p), 64'd2);

    // Clear coinciding with an increment.
    store(32'h8000_0018, 32'hFFFF_FFFF);
    bus.io_inst_valid = 1'b1;
    bus.io_br_valid   = 1'b1;
    bus.io_br_correct = 1'b1;
    tick();
    idle_bus();
    bus.io_addr = 32'h0000_1000;
    settle();
    chk("clr_cycle", 64'(bus.io_cycle_p), 64'd0);
    chk("clr_inst", 64'(bus.io_inst_p), 64'd0);
    chk("clr_total", 64'(bus.io_total_B_p), 64'd0);
    chk("clr_corr", 64'(bus.io_corr_B_p), 64'd0);
    tick();
    chk("clr_cycle_resume", 64'(bus.io_cycle_p), 64'd1);

    // Stall: no side effects, prev address frozen at 0x1000.
    bus.io_stall = 1'b1;
    store(32'h8000_0008, 32'h0000_0055);
    tick();
    idle_bus();
    settle();
    chk("stall_tx_valid", 64'(bus.io_uart_tx_data_in_valid), 64'd0);
    chk("stall_tx_idle", 64'(bus.io_tx_idle), 64'd1);
    chk("stall_prev1", 64'(bus.io_prev_data_addr), 64'h0000_1000);
    chk("stall_cycle_runs", 64'(bus.io_cycle_p), 64'd2);
    bus.io_addr = 32'h8000_0004;
    bus.io_re   = 1'b1;
    bus.io_rx_fifo_empty = 1'b0;
    settle();
    chk("stall_rx_nopop", 64'(bus.io_rx_fifo_rd_en), 64'd0);
    tick();
    idle_bus();
    bus.io_rx_fifo_empty = 1'b1;
    settle();
    chk("stall_prev2", 64'(bus.io_prev_data_addr), 64'h0000_1000);
    bus.io_stall = 1'b0;

    // Halt feature: clear, set halt, wait 8, release, run 3.
    store(32'h8000_0018, 32'h0);
    tick();
    store(32'h8000_0024, 32'h1);
    tick();
    idle_bus();
    for (int i = 0; i < 8; i++) tick();
`ifdef MMIO_CNT_HALT_EN
    chk("halt_frozen", 64'(bus.io_cycle_p), 64'd1);
`else
    chk("nohalt_runs", 64'(bus.io_cycle_p), 64'd9);
`endif
    store(32'h8000_0024, 32'h0);
    tick();
    idle_bus();
    for (int i = 0; i < 3; i++) tick();
`ifdef MMIO_CNT_HALT_EN
    chk("halt_resume", 64'(bus.io_cycle_p), 64'd4);
`else
    chk("nohalt_resume", 64'(bus.io_cycle_p), 64'd13);
`endif

    // Synchronous reset mid-handshake drops the pending byte.
    store(32'h8000_0008, 32'h0000_0099);
    tick();
    idle_bus();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    settle();
    chk("rst_mid_tx_idle", 64'(bus.io_tx_idle), 64'd1);
    chk("rst_mid_tx_byte", 64'(bus.io_uart_tx_data_in), 64'h0);
    chk("rst_mid_cycle", 64'(bus.io_cycle_p), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
